mips32_fetch_queue: RTL and testbench

Instruction prefetch queue sitting directly upstream of the pipeline's IF/ID latch. Issues word-addressed reads to instruction memory ahead of demand. Buffers returned instructions in a small in-order FIFO and presents them with their next-PC to the decode stage over a valid/ready handshake. Flushes on branch redirect and stops fetching on halt.

---
 rtl/mips32_fetch_queue.sv | 196 +++++++++++++++++++
 tb/tb_mips32_fetch_queue.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_fetch_queue.sv
//------------------------------------------------------------------------------
// Module      : mips32_fetch_queue
// Description : Instruction prefetch queue sitting upstream of the IF/ID latch.
//               Issues word-addressed reads ahead of demand. Buffers the
//               returned words with their next-PC in an in-order FIFO and
//               hands them to decode over a valid/ready handshake. Flushes on
//               branch redirect and stops fetching on halt.
// Parameters  : DEPTH    - FIFO entries; also the in-flight + buffered credit
//                          limit (power of two, >= 2)
//               AW       - instruction word-address width
//               RESET_PC - fetch address after reset
// Ports       : clk, rst_n             clock, async active-low reset
//               imem_req_valid/addr/ready   instruction memory request
//               imem_rsp_valid/data         in-order read response
//               redirect_valid/redirect_pc  taken-branch restart
//               halt                        stop issuing requests
//               out_valid/out_ir/out_npc/out_ready  decode-side handshake
//               occupancy                   buffered entries
// Macro       : FETCHQ_BYPASS_EN - when defined, a response arriving at an
//               empty FIFO is presented combinationally in the same cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips32_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          AW       = 10,
   parameter int unsigned RESET_PC = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     imem_req_valid,
   output logic [AW-1:0]            imem_req_addr,
   input  logic                     imem_req_ready,
   input  logic                     imem_rsp_valid,
   input  logic [31:0]              imem_rsp_data,
   input  logic                     redirect_valid,
   input  logic [AW-1:0]            redirect_pc,
   input  logic                     halt,
   output logic                     out_valid,
   output logic [31:0]              out_ir,
   output logic [31:0]              out_npc,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

   typedef enum logic {
      S_FETCH  = 1'b0,
      S_HALTED = 1'b1
   } state_t;

   state_t        state_q;
   logic [AW-1:0] pc_q;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_q;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [PW-1:0] tag_rd_q, tag_wr_q;
   logic [31:0]   ir_mem_q  [DEPTH];
   logic [AW-1:0] npc_mem_q [DEPTH];
   logic [AW-1:0] tag_mem_q [DEPTH];

   logic [AW-1:0] pc_inc;
   logic [CW:0]   used;
   logic          credit_ok;
   logic          req_fire;
   logic          rsp_keep;
   logic          rsp_drop;
   logic          head_valid;
   logic          fifo_push;
   logic          fifo_pop;
   logic [AW-1:0] npc_sel;

   // npc is computed AW-wide so it wraps with the address space
   assign pc_inc = pc_q + AW'(1);

   // Credit covers buffered entries plus every outstanding request,
   // including the ones that will be dropped, so the FIFO can never overflow.
   assign used      = {1'b0, count_q} + {1'b0, inflight_q};
   assign credit_ok = (used < DEPTH_C);

   assign imem_req_valid = (state_q == S_FETCH) && !halt && credit_ok;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response in the redirect cycle belongs to the flushed stream.
   assign rsp_drop   = imem_rsp_valid && ((drop_q != '0) || redirect_valid);
   assign rsp_keep   = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
   assign head_valid = (count_q != '0);

`ifdef FETCHQ_BYPASS_EN
   logic bypass;

   assign bypass    = rsp_keep && !head_valid;
   assign out_valid = head_valid || bypass;
   assign out_ir    = bypass ? imem_rsp_data : ir_mem_q[rd_ptr_q];
   assign npc_sel   = bypass ? tag_mem_q[tag_rd_q] : npc_mem_q[rd_ptr_q];
   // A bypassed word taken by the consumer never touches the storage.
   assign fifo_push = rsp_keep && !(bypass && out_ready);
   assign fifo_pop  = head_valid && out_ready;
`else
   assign out_valid = head_valid;
   assign out_ir    = ir_mem_q[rd_ptr_q];
   assign npc_sel   = npc_mem_q[rd_ptr_q];
   assign fifo_push = rsp_keep;
   assign fifo_pop  = head_valid && out_ready;
`endif

   assign out_npc   = 32'(npc_sel);
   assign occupancy = count_q;

   always_comb begin
      inflight_d = inflight_q;
      if (req_fire) begin
         inflight_d = inflight_d + ONE_C;
      end
      if (imem_rsp_valid) begin
         inflight_d = inflight_d - ONE_C;
      end
   end

   always_comb begin
      count_d = count_q;
      if (fifo_push) begin
         count_d = count_d + ONE_C;
      end
      if (fifo_pop) begin
         count_d = count_d - ONE_C;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         pc_q       <= AW'(RESET_PC);
         inflight_q <= '0;
         drop_q     <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         tag_rd_q   <= '0;
         tag_wr_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ir_mem_q[i]  <= '0;
            npc_mem_q[i] <= '0;
            tag_mem_q[i] <= '0;
         end
      end else begin
         inflight_q <= inflight_d;
         if (redirect_valid) begin
            // Everything still outstanding next cycle, including a request
            // accepted right now, returns stale data and must be discarded.
            state_q  <= S_FETCH;
            pc_q     <= redirect_pc;
            drop_q   <= inflight_d;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            tag_rd_q <= '0;
            tag_wr_q <= '0;
         end else begin
            if (halt) begin
               state_q <= S_HALTED;
            end
            if (req_fire) begin
               pc_q                <= pc_inc;
               tag_mem_q[tag_wr_q] <= pc_inc;
               tag_wr_q            <= tag_wr_q + PW'(1);
            end
            if (rsp_drop) begin
               drop_q <= drop_q - ONE_C;
            end
            if (rsp_keep) begin
               tag_rd_q <= tag_rd_q + PW'(1);
            end
            if (fifo_push) begin
               ir_mem_q[wr_ptr_q]  <= imem_rsp_data;
               npc_mem_q[wr_ptr_q] <= tag_mem_q[tag_rd_q];
               wr_ptr_q            <= wr_ptr_q + PW'(1);
            end
            if (fifo_pop) begin
               rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mips32_fetch_queue.sv
//------------------------------------------------------------------------------
// Module      : tb_mips32_fetch_queue
// Description : Directed self-checking bench for mips32_fetch_queue with a
//               fixed-latency in-order instruction memory model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mips32_fetch_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          imem_req_valid;
   logic [AW-1:0] imem_req_addr;
   logic          imem_req_ready = 1'b1;
   logic          imem_rsp_valid = 1'b0;
   logic [31:0]   imem_rsp_data = '0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          halt = 1'b0;
   logic          out_valid;
   logic [31:0]   out_ir;
   logic [31:0]   out_npc;
   logic          out_ready = 1'b0;
   logic [$clog2(DEPTH):0] occupancy;

   int n_cmp = 0;
   int n_bad = 0;

   mips32_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(0)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .out_valid      (out_valid),
      .out_ir         (out_ir),
      .out_npc        (out_npc),
      .out_ready      (out_ready),
      .occupancy      (occupancy)
   );

   always #5 clk = ~clk;

   // Memory model: word at address a is 0xC0DE0000 | a, returned in order
   // mem_lat cycles after acceptance. Also logs accepts and pops.
   int unsigned   cyc = 0;
   int unsigned   mem_lat = 1;
   logic [AW-1:0] mq_addr [$];
   int unsigned   mq_due  [$];
   logic [AW-1:0] acc_addr [$];
   logic [31:0]   pop_ir   [$];
   logic [31:0]   pop_npc  [$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq_addr.delete();
         mq_due.delete();
         acc_addr.delete();
         pop_ir.delete();
         pop_npc.delete();
         cyc = 0;
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end else begin
         cyc = cyc + 1;
         if (out_valid && out_ready) begin
            pop_ir.push_back(out_ir);
            pop_npc.push_back(out_npc);
         end
         if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + mem_lat - 1);
            acc_addr.push_back(imem_req_addr);
         end
         #1;
         if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hC0DE_0000 | 32'(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset(input int unsigned lat);
      rst_n          = 1'b0;
      halt           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;
      imem_req_ready = 1'b1;
      mem_lat        = lat;
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      halt           = 1'b0;
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      mem_lat        = 1;
      tick(1);
      n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL reset_req_valid: got %b want 1", imem_req_valid); end
      n_cmp++; if (imem_req_addr !== 10'd0) begin n_bad++; $display("FAIL reset_req_addr: got %0h want 0", imem_req_addr); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_ir !== 32'd0) begin n_bad++; $display("FAIL reset_out_ir: got %h want 0", out_ir); end
      n_cmp++; if (out_npc !== 32'd0) begin n_bad++; $display("FAIL reset_out_npc: got %h want 0", out_npc); end
      n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
      tick(1);
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      logic [31:0] exp;
      tick(1);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_first_cycle_valid: got %b want 0", out_valid); end
      tick(1);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_first_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_npc !== 32'd1) begin n_bad++; $display("FAIL stream_first_npc: got %h want 1", out_npc); end
      n_cmp++; if (out_ir !== 32'hC0DE_0000) begin n_bad++; $display("FAIL stream_first_ir: got %h want c0de0000", out_ir); end
      tick(8);
      for (int i = 0; i < 8; i++) begin
         exp = 32'(i);
         n_cmp++;
         if (acc_addr.size() <= i || 32'(acc_addr[i]) !== exp) begin
            n_bad++;
            $display("FAIL stream_addr[%0d]: got %h want %h", i, (acc_addr.size() > i) ? 32'(acc_addr[i]) : 32'hFFFF_FFFF, exp);
         end
      end
      for (int i = 0; i < 6; i++) begin
         exp = 32'(i + 1);
         n_cmp++;
         if (pop_npc.size() <= i || pop_npc[i] !== exp) begin
            n_bad++;
            $display("FAIL stream_npc[%0d]: got %h want %h", i, (pop_npc.size() > i) ? pop_npc[i] : 32'hFFFF_FFFF, exp);
         end
      end
      n_cmp++; if (occupancy !== 3'd1) begin n_bad++; $display("FAIL stream_occupancy: got %0d want 1", occupancy); end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp;
      do_reset(1);
      tick(8);
      n_cmp++; if (acc_addr.size() != 4) begin n_bad++; $display("FAIL bp_accepts: got %0d want 4", acc_addr.size()); end
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
      n_cmp++; if (occupancy !== 3'd4) begin n_bad++; $display("FAIL bp_occupancy: got %0d want 4", occupancy); end
      n_cmp++; if (out_npc !== 32'd1) begin n_bad++; $display("FAIL bp_head_npc: got %h want 1", out_npc); end
      out_ready = 1'b1;
      tick(8);
      for (int i = 0; i < 5; i++) begin
         exp = 32'(i + 1);
         n_cmp++;
         if (pop_npc.size() <= i || pop_npc[i] !== exp) begin
            n_bad++;
            $display("FAIL bp_pop_npc[%0d]: got %h want %h", i, (pop_npc.size() > i) ? pop_npc[i] : 32'hFFFF_FFFF, exp);
         end
      end
      n_cmp++;
      if (acc_addr.size() <= 4 || acc_addr[4] !== 10'd4) begin
         n_bad++;
         $display("FAIL bp_resume_addr: got %h want 004", (acc_addr.size() > 4) ? acc_addr[4] : 10'h3FF);
      end
   endtask

   task automatic test_redirect();
      do_reset(3);
      out_ready = 1'b1;
      tick(2);
      n_cmp++; if (acc_addr.size() != 2) begin n_bad++; $display("FAIL redir_inflight: got %0d want 2", acc_addr.size()); end
      redirect_valid = 1'b1;
      redirect_pc    = 10'h200;
      imem_req_ready = 1'b0;
      tick(1);
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      tick(12);
      n_cmp++;
      if (acc_addr.size() <= 2 || acc_addr[2] !== 10'h200) begin
         n_bad++;
         $display("FAIL redir_addr: got %h want 200", (acc_addr.size() > 2) ? acc_addr[2] : 10'h3FF);
      end
      n_cmp++;
      if (pop_npc.size() < 1 || pop_npc[0] !== 32'h201) begin
         n_bad++;
         $display("FAIL redir_npc0: got %h want 201", (pop_npc.size() > 0) ? pop_npc[0] : 32'hFFFF_FFFF);
      end
      n_cmp++;
      if (pop_ir.size() < 1 || pop_ir[0] !== 32'hC0DE_0200) begin
         n_bad++;
         $display("FAIL redir_ir0: got %h want c0de0200", (pop_ir.size() > 0) ? pop_ir[0] : 32'hFFFF_FFFF);
      end
      n_cmp++;
      if (pop_npc.size() < 2 || pop_npc[1] !== 32'h202) begin
         n_bad++;
         $display("FAIL redir_npc1: got %h want 202", (pop_npc.size() > 1) ? pop_npc[1] : 32'hFFFF_FFFF);
      end
   endtask

   task automatic test_halt();
      do_reset(1);
      tick(3);
      halt = 1'b1;
      tick(1);
      halt = 1'b0;
      tick(4);
      n_cmp++; if (acc_addr.size() != 3) begin n_bad++; $display("FAIL halt_accepts: got %0d want 3", acc_addr.size()); end
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL halt_req_valid: got %b want 0", imem_req_valid); end
      n_cmp++; if (occupancy !== 3'd3) begin n_bad++; $display("FAIL halt_occupancy: got %0d want 3", occupancy); end
      out_ready = 1'b1;
      tick(5);
      n_cmp++; if (pop_npc.size() != 3) begin n_bad++; $display("FAIL halt_drained: got %0d want 3", pop_npc.size()); end
      n_cmp++;
      if (pop_npc.size() < 3 || pop_npc[2] !== 32'd3) begin
         n_bad++;
         $display("FAIL halt_last_npc: got %h want 3", (pop_npc.size() > 2) ? pop_npc[2] : 32'hFFFF_FFFF);
      end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL halt_empty: got %b want 0", out_valid); end
      redirect_valid = 1'b1;
      redirect_pc    = 10'h010;
      tick(1);
      redirect_valid = 1'b0;
      tick(4);
      n_cmp++;
      if (acc_addr.size() <= 3 || acc_addr[3] !== 10'h010) begin
         n_bad++;
         $display("FAIL halt_restart_addr: got %h want 010", (acc_addr.size() > 3) ? acc_addr[3] : 10'h3FF);
      end
      n_cmp++;
      if (pop_npc.size() <= 3 || pop_npc[3] !== 32'h011) begin
         n_bad++;
         $display("FAIL halt_restart_npc: got %h want 011", (pop_npc.size() > 3) ? pop_npc[3] : 32'hFFFF_FFFF);
      end
   endtask

   task automatic test_wrap();
      do_reset(1);
      out_ready      = 1'b1;
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 10'h3FF;
      tick(1);
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      tick(6);
      n_cmp++;
      if (acc_addr.size() < 2 || acc_addr[0] !== 10'h3FF || acc_addr[1] !== 10'h000) begin
         n_bad++;
         $display("FAIL wrap_addr: got %h,%h want 3ff,000",
                  (acc_addr.size() > 0) ? acc_addr[0] : 10'h155, (acc_addr.size() > 1) ? acc_addr[1] : 10'h155);
      end
      n_cmp++;
      if (pop_npc.size() < 1 || pop_npc[0] !== 32'd0) begin
         n_bad++;
         $display("FAIL wrap_npc0: got %h want 0", (pop_npc.size() > 0) ? pop_npc[0] : 32'hFFFF_FFFF);
      end
      n_cmp++;
      if (pop_ir.size() < 1 || pop_ir[0] !== 32'hC0DE_03FF) begin
         n_bad++;
         $display("FAIL wrap_ir0: got %h want c0de03ff", (pop_ir.size() > 0) ? pop_ir[0] : 32'hFFFF_FFFF);
      end
      n_cmp++;
      if (pop_npc.size() < 2 || pop_npc[1] !== 32'd1) begin
         n_bad++;
         $display("FAIL wrap_npc1: got %h want 1", (pop_npc.size() > 1) ? pop_npc[1] : 32'hFFFF_FFFF);
      end
   endtask

   task automatic test_async_reset();
      do_reset(1);
      tick(4);
      n_cmp++; if (occupancy !== 3'd3) begin n_bad++; $display("FAIL areset_pre_occupancy: got %0d want 3", occupancy); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL areset_occupancy: got %0d want 0", occupancy); end
      n_cmp++; if (imem_req_addr !== 10'd0) begin n_bad++; $display("FAIL areset_req_addr: got %h want 0", imem_req_addr); end
      #4;
      rst_n = 1'b1;
      tick(3);
      n_cmp++;
      if (acc_addr.size() < 1 || acc_addr[0] !== 10'd0) begin
         n_bad++;
         $display("FAIL areset_restart_addr: got %h want 0", (acc_addr.size() > 0) ? acc_addr[0] : 10'h3FF);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_wrap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
